// File: rtl/dm_cache_ctrl_if.sv
// rtl/dm_cache_ctrl_if.sv - CPU, backing-memory and data-RAM signal bundle for dm_cache_ctrl
//
// Groups every non-clock/reset port of the cache controller.
//   cpu_*  : CPU read request/response (cpu_valid/cpu_ready accept, cpu_rvalid strobe)
//   mem_*  : backing-memory word read (mem_req held until mem_ack pulses)
//   data_* : external data RAM port, synchronous read with 1-cycle latency
// Modports:
//   slave  : the cache controller side
//   master : the environment side (CPU, backing memory, data RAM)

interface dm_cache_ctrl_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
);
    logic                        cpu_valid;
    logic [ADDR_W-1:0]           cpu_addr;
    logic                        cpu_flush;
    logic                        cpu_ready;
    logic                        cpu_rvalid;
    logic                        cpu_hit;
    logic [DATA_W-1:0]           cpu_rdata;

    logic                        mem_req;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_ack;
    logic [DATA_W-1:0]           mem_rdata;

    logic                        data_we;
    logic [INDEX_W+OFFSET_W-1:0] data_addr;
    logic [DATA_W-1:0]           data_wdata;
    logic [DATA_W-1:0]           data_rdata;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_flush,
        output cpu_ready, cpu_rvalid, cpu_hit, cpu_rdata,
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output data_we, data_addr, data_wdata,
        input  data_rdata
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_flush,
        input  cpu_ready, cpu_rvalid, cpu_hit, cpu_rdata,
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  data_we, data_addr, data_wdata,
        output data_rdata
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - sequencing controller for a direct-mapped read cache
//
// 2**INDEX_W lines of 2**OFFSET_W words; holds the tag and valid arrays, drives
// the external data RAM and the backing memory. One CPU read in flight at a time:
// a hit answers from the data RAM two cycles after accept, a miss refills the
// whole line (words 0..15 in order) and then answers with the requested word.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : dm_cache_ctrl_if - cpu_*, mem_*, data_* groups
//   stat_hits        : saturating hit count   (only with CACHE_STATS_EN)
//   stat_misses      : saturating miss count  (only with CACHE_STATS_EN)
//
// Optional feature macro: CACHE_STATS_EN

module dm_cache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dm_cache_ctrl_if.slave        bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESP
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [ADDR_W-1:0]     addr_q;
    logic [OFFSET_W-1:0]   word_cnt_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  hit_q;
    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_mem [LINES];

    logic [TAG_W-1:0]      tag_f;
    logic [INDEX_W-1:0]    idx_f;
    logic [OFFSET_W-1:0]   off_f;

    logic                  accept;
    logic                  flush;
    logic                  lookup_hit;
    logic                  refill_ack;
    logic                  refill_done;

    assign tag_f = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_f = addr_q[OFFSET_W +: INDEX_W];
    assign off_f = addr_q[OFFSET_W-1:0];

    // Tag compare reads the tag array combinationally during LOOKUP.
    assign lookup_hit  = valid_q[idx_f] && (tag_mem[idx_f] == tag_f);
    assign refill_ack  = (state_q == S_REFILL) && bus.mem_ack;
    assign refill_done = refill_ack && (word_cnt_q == {OFFSET_W{1'b1}});

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Flush has priority over a simultaneous request.
                flush  = bus.cpu_flush;
                accept = bus.cpu_valid && !bus.cpu_flush;
                if (accept) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = lookup_hit ? S_RESP : S_REFILL;
            end
            S_REFILL: begin
                if (refill_done) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.cpu_ready  = (state_q == S_IDLE) && !bus.cpu_flush;
        bus.cpu_rvalid = (state_q == S_RESP);
        bus.cpu_hit    = hit_q;
        bus.cpu_rdata  = rdata_q;

        bus.mem_req    = (state_q == S_REFILL);
        bus.mem_addr   = '0;
        if (state_q == S_REFILL) begin
            bus.mem_addr = {tag_f, idx_f, word_cnt_q};
        end

        bus.data_we    = refill_ack;
        bus.data_wdata = refill_ack ? bus.mem_rdata : '0;

        // The data RAM read address goes out in the accept cycle itself so the
        // word is already on data_rdata during LOOKUP.
        bus.data_addr  = '0;
        if (accept) begin
            bus.data_addr = bus.cpu_addr[INDEX_W+OFFSET_W-1:0];
        end else if (state_q == S_REFILL) begin
            bus.data_addr = {idx_f, word_cnt_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            word_cnt_q <= '0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (accept) begin
                        addr_q <= bus.cpu_addr;
                    end
                end
                S_LOOKUP: begin
                    hit_q <= lookup_hit;
                    if (lookup_hit) begin
                        rdata_q <= bus.data_rdata;
                    end else begin
                        word_cnt_q <= '0;
                    end
                end
                S_REFILL: begin
                    if (bus.mem_ack) begin
                        // Wraps 15->0 on the final ack, which is also the exit.
                        word_cnt_q <= word_cnt_q + 1'b1;
                        if (word_cnt_q == off_f) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        if (refill_done) begin
                            valid_q[idx_f] <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag storage is plain RAM: it is not cleared by reset, validity lives in valid_q.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_mem[idx_f] <= tag_f;
        end
    end

`ifdef CACHE_STATS_EN
    logic enter_resp;
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (enter_resp) begin
            if (state_q == S_LOOKUP) begin
                if (stat_hits != 32'hFFFF_FFFF) begin
                    stat_hits <= stat_hits + 32'd1;
                end
            end else begin
                if (stat_misses != 32'hFFFF_FFFF) begin
                    stat_misses <= stat_misses + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - scoreboard testbench for dm_cache_ctrl

module tb_dm_cache_ctrl;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_cache_ctrl_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)
    ) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    dm_cache_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    typedef struct {
        logic        hit;
        logic [31:0] rdata;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem_log[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned resp_count = 0;
    int unsigned req_cycles = 0;
    int unsigned ack_count = 0;
    bit          mvalid [256];
    logic [19:0] mtag [256];
    int unsigned m_hits = 0;
    int unsigned m_misses = 0;
    logic [31:0] dram [4096];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous data RAM, one cycle read latency.
    always @(posedge clk) begin
        if (bus.data_we) dram[bus.data_addr] <= bus.data_wdata;
        bus.data_rdata <= dram[bus.data_addr];
    end

    // Backing memory: acks each requested word after a random 0..2 cycle gap.
    initial begin
        int gap;
        gap = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (bus.mem_req && rst_n) begin
                if (gap == 0) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                    mem_log.push_back(bus.mem_addr);
                    ack_count++;
                    gap = $urandom_range(0, 2);
                end else begin
                    gap--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every response strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_req) req_cycles++;
            if (bus.cpu_rvalid) begin
                resp_count++;
                check("rvalid_expected", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("cpu_hit", 64'(bus.cpu_hit), 64'(e.hit));
                    check("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.rdata));
                    if (e.hit) check("hit_latency", 64'(cyc - e.acc_cyc), 64'd2);
                end
            end
        end
    end

    task automatic check_zero_outputs();
        check("rst_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
        check("rst_cpu_hit",    64'(bus.cpu_hit),    64'd0);
        check("rst_cpu_rdata",  64'(bus.cpu_rdata),  64'd0);
        check("rst_mem_req",    64'(bus.mem_req),    64'd0);
        check("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
        check("rst_data_we",    64'(bus.data_we),    64'd0);
        check("rst_data_addr",  64'(bus.data_addr),  64'd0);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.cpu_ready) break;
        end
        check("accept_ready", 64'(bus.cpu_ready), 64'd1);
    endtask

    // Called at #1 after a rising edge with the controller idle.
    task automatic do_read(input logic [31:0] a);
        exp_t        e;
        int          idx;
        int unsigned rc0;
        int unsigned rq0;
        logic        ok;
        idx = int'(a[11:4]);
        e.hit = mvalid[idx] && (mtag[idx] == a[31:12]);
        e.rdata = mem_word(a);
        mem_log.delete();
        rq0 = req_cycles;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr = a;
        wait_ready();
        e.acc_cyc = cyc;
        rc0 = resp_count;
        sbq.push_back(e);
        mvalid[idx] = 1'b1;
        mtag[idx] = a[31:12];
        if (e.hit) m_hits++; else m_misses++;
        @(posedge clk);
        #1;
        bus.cpu_valid = 1'b0;
        bus.cpu_addr = $urandom;
        for (int k = 0; k < 2000 && resp_count == rc0; k++) @(negedge clk);
        check("response_seen", 64'(resp_count != rc0), 64'd1);
        if (e.hit) begin
            check("hit_mem_req_cycles", 64'(req_cycles - rq0), 64'd0);
        end else begin
            ok = (mem_log.size() == 16);
            for (int i = 0; i < 16 && ok; i++) begin
                ok = (mem_log[i] == {a[31:4], 4'(i)});
            end
            check("refill_sequence", 64'(ok), 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic with_valid);
        bus.cpu_flush = 1'b1;
        bus.cpu_valid = with_valid;
        bus.cpu_addr = 32'h0000_1234;
        @(negedge clk);
        check("ready_during_flush", 64'(bus.cpu_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.cpu_flush = 1'b0;
        bus.cpu_valid = 1'b0;
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
    endtask

    initial begin
        int unsigned a0;
        logic [19:0] t;
        logic [7:0]  ix;
        bus.cpu_valid = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_flush = 1'b0;
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check_zero_outputs();
        check("rst_cpu_ready", 64'(bus.cpu_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_read(32'h0000_1234);
        do_read(32'h0000_1234);
        do_read(32'h0000_2234);
        do_read(32'h0000_1234);
        do_flush(1'b1);
        do_read(32'h0000_1234);
        do_read(32'h0000_1239);

        // Reset in the middle of a refill.
        bus.cpu_valid = 1'b1;
        bus.cpu_addr = 32'h0000_2234;
        wait_ready();
        @(posedge clk);
        #1;
        bus.cpu_valid = 1'b0;
        a0 = ack_count;
        for (int k = 0; k < 500 && (ack_count - a0) < 7; k++) @(posedge clk);
        check("acks_before_reset", 64'(ack_count - a0), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs();
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
`ifdef CACHE_STATS_EN
        m_hits = 0;
        m_misses = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_read(32'h0000_1234);
        do_read(32'h0000_1234);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: t = 20'h00000;
                1: t = 20'h00001;
                2: t = 20'hFFFFF;
                default: t = 20'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: ix = 8'h23;
                1: ix = 8'h05;
                2: ix = 8'hFF;
                default: ix = 8'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) do_flush(1'($urandom_range(0, 1)));
            do_read({t, ix, 4'($urandom)});
        end

`ifdef CACHE_STATS_EN
        check("stat_hits", 64'(stat_hits), 64'(m_hits));
        check("stat_misses", 64'(stat_misses), 64'(m_misses));
`endif
        repeat (4) @(posedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
